// File: rtl/xnor_match_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xnor_match_checker_if : bit-in / frame-result handshake bundle        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface xnor_match_checker_if #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1),
    parameter int IDX_W     = $clog2(FRAME_LEN)
);
    logic             in_valid;
    logic             match;
    logic             in_ready;
    logic             res_valid;
    logic             res_ready;
    logic             res_equal;
    logic [CNT_W-1:0] res_mismatches;
    logic [IDX_W-1:0] res_first_err;

    modport master (
        output in_valid, match, res_ready,
        input  in_ready, res_valid, res_equal, res_mismatches, res_first_err
    );

    modport slave (
        input  in_valid, match, res_ready,
        output in_ready, res_valid, res_equal, res_mismatches, res_first_err
    );
endinterface
`default_nettype wire

// File: rtl/xnor_match_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xnor_match_checker : frames per-bit match flags, reports equality,    |
// | mismatch count and first mismatch index.  Rev 1.0                    |
// +----------------------------------------------------------------------+
module xnor_match_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1),
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xnor_match_checker_if.slave   bus
);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_REPORT  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;
    logic [IDX_W-1:0]   first_idx_q, first_idx_d;
    logic               err_seen_q, err_seen_d;
    logic               res_valid_q, res_valid_d;
    logic               res_equal_q, res_equal_d;
    logic [CNT_W-1:0]   res_mis_q, res_mis_d;
    logic [IDX_W-1:0]   res_first_q, res_first_d;

    logic               w_accept;
    logic               w_miss;
    logic [CNT_W-1:0]   w_mis_upd;
    logic [IDX_W-1:0]   w_first_upd;
    logic               w_err_upd;

    assign w_accept    = bus.in_valid && (state_q == S_COLLECT);
    assign w_miss      = ~bus.match;
    // Counter values as they will stand once the current bit is included
    assign w_mis_upd   = mis_cnt_q + CNT_W'(w_miss);
    assign w_first_upd = (w_miss && !err_seen_q) ? bit_cnt_q : first_idx_q;
    assign w_err_upd   = err_seen_q | w_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            bit_cnt_q   <= '0;
            mis_cnt_q   <= '0;
            first_idx_q <= '0;
            err_seen_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_equal_q <= 1'b0;
            res_mis_q   <= '0;
            res_first_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
            first_idx_q <= first_idx_d;
            err_seen_q  <= err_seen_d;
            res_valid_q <= res_valid_d;
            res_equal_q <= res_equal_d;
            res_mis_q   <= res_mis_d;
            res_first_q <= res_first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        first_idx_d = first_idx_q;
        err_seen_d  = err_seen_q;
        res_valid_d = res_valid_q;
        res_equal_d = res_equal_q;
        res_mis_d   = res_mis_q;
        res_first_d = res_first_q;

        case (state_q)
            S_COLLECT: begin
                if (w_accept) begin
                    mis_cnt_d   = w_mis_upd;
                    first_idx_d = w_first_upd;
                    err_seen_d  = w_err_upd;
                    if (bit_cnt_q == c_LAST_IDX) begin
                        state_d     = S_REPORT;
                        res_valid_d = 1'b1;
                        res_equal_d = (w_mis_upd == '0);
                        res_mis_d   = w_mis_upd;
                        res_first_d = w_err_upd ? w_first_upd : '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + IDX_W'(1);
                    end
                end
            end
            S_REPORT: begin
                // Frame state is cleared on handshake; result data stays put
                if (bus.res_ready) begin
                    state_d     = S_COLLECT;
                    bit_cnt_d   = '0;
                    mis_cnt_d   = '0;
                    first_idx_d = '0;
                    err_seen_d  = 1'b0;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    assign bus.in_ready       = (state_q == S_COLLECT);
    assign bus.res_valid      = res_valid_q;
    assign bus.res_equal      = res_equal_q;
    assign bus.res_mismatches = res_mis_q;
    assign bus.res_first_err  = res_first_q;
endmodule
`default_nettype wire

// File: tb/tb_xnor_match_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_xnor_match_checker : directed and randomized frame checks          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_xnor_match_checker;
    localparam int FL = 8;
    localparam int CW = $clog2(FL + 1);
    localparam int IW = $clog2(FL);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    xnor_match_checker_if #(.FRAME_LEN(FL)) bus ();

    xnor_match_checker #(.FRAME_LEN(FL)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference: bit i of a frame word is the i-th accepted match flag
    function automatic int ref_mis(input logic [FL-1:0] f);
        int n = 0;
        for (int i = 0; i < FL; i++) if (f[i] == 1'b0) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [FL-1:0] f);
        for (int i = 0; i < FL; i++) if (f[i] == 1'b0) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic m);
        bus.in_valid = 1'b1;
        bus.match    = m;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [FL-1:0] f);
        for (int i = 0; i < FL; i++) send_bit(f[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset res_valid: got %b expected 0", bus.res_valid); end
        checks++; if (bus.res_equal !== 1'b0) begin errors++; $display("FAIL reset res_equal: got %b expected 0", bus.res_equal); end
        checks++; if (bus.res_mismatches !== CW'(0)) begin errors++; $display("FAIL reset res_mismatches: got %0d expected 0", bus.res_mismatches); end
        checks++; if (bus.res_first_err !== IW'(0)) begin errors++; $display("FAIL reset res_first_err: got %0d expected 0", bus.res_first_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exact_match();
        logic [FL-1:0] f;
        f = '1;
        bus.res_ready = 1'b1;
        send_frame(f);
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL exact res_valid: got %b expected 1", bus.res_valid); end
        checks++; if (bus.res_equal !== 1'b1) begin errors++; $display("FAIL exact res_equal: got %b expected 1", bus.res_equal); end
        checks++; if (bus.res_mismatches !== CW'(ref_mis(f))) begin errors++; $display("FAIL exact res_mismatches: got %0d expected %0d", bus.res_mismatches, ref_mis(f)); end
        checks++; if (bus.res_first_err !== IW'(ref_first(f))) begin errors++; $display("FAIL exact res_first_err: got %0d expected %0d", bus.res_first_err, ref_first(f)); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL exact in_ready during report: got %b expected 0", bus.in_ready); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL exact res_valid after handshake: got %b expected 0", bus.res_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL exact in_ready after handshake: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_partial_mismatch();
        logic [FL-1:0] f;
        f = 8'b1101_1011;  // sequence 1,1,0,1,1,0,1,1 from bit 0
        bus.res_ready = 1'b1;
        send_frame(f);
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL partial res_valid: got %b expected 1", bus.res_valid); end
        checks++; if (bus.res_equal !== 1'b0) begin errors++; $display("FAIL partial res_equal: got %b expected 0", bus.res_equal); end
        checks++; if (bus.res_mismatches !== CW'(2)) begin errors++; $display("FAIL partial res_mismatches: got %0d expected 2", bus.res_mismatches); end
        checks++; if (bus.res_first_err !== IW'(2)) begin errors++; $display("FAIL partial res_first_err: got %0d expected 2", bus.res_first_err); end
        tick();
    endtask

    task automatic test_gaps();
        int extra;
        bus.res_ready = 1'b1;
        for (int i = 0; i < FL; i++) begin
            if (i == 4) repeat (2) tick();
            send_bit(1'b0);
        end
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL gaps res_valid: got %b expected 1", bus.res_valid); end
        checks++; if (bus.res_mismatches !== CW'(FL)) begin errors++; $display("FAIL gaps res_mismatches: got %0d expected %0d", bus.res_mismatches, FL); end
        checks++; if (bus.res_first_err !== IW'(0)) begin errors++; $display("FAIL gaps res_first_err: got %0d expected 0", bus.res_first_err); end
        checks++; if (bus.res_equal !== 1'b0) begin errors++; $display("FAIL gaps res_equal: got %b expected 0", bus.res_equal); end
        extra = 0;
        repeat (5) begin
            tick();
            if (bus.res_valid === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL gaps extra results: got %0d expected 0", extra); end
    endtask

    task automatic test_backpressure();
        logic [FL-1:0] f;
        logic [FL-1:0] f2;
        int bad;
        f = FL'($urandom);
        f[3] = 1'b0;
        bus.res_ready = 1'b0;
        send_frame(f);
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp res_valid: got %b expected 1", bus.res_valid); end
        bad = 0;
        bus.in_valid = 1'b1;
        repeat (5) begin
            bus.match = 1'($urandom);
            tick();
            if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 ||
                bus.res_mismatches !== CW'(ref_mis(f)) ||
                bus.res_first_err !== IW'(ref_first(f)) || bus.res_equal !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp stall stability: got %0d bad cycles expected 0 (mis %0d exp %0d)", bad, bus.res_mismatches, ref_mis(f)); end
        bus.res_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp handshake: got valid %b ready %b expected 0 1", bus.res_valid, bus.in_ready); end
        f2 = FL'($urandom);
        send_frame(f2);
        checks++; if (bus.res_mismatches !== CW'(ref_mis(f2)) || bus.res_first_err !== IW'(ref_first(f2)) || bus.res_valid !== 1'b1) begin
            errors++; $display("FAIL bp next frame: got mis %0d first %0d valid %b expected mis %0d first %0d valid 1", bus.res_mismatches, bus.res_first_err, bus.res_valid, ref_mis(f2), ref_first(f2));
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [FL-1:0] f;
        bus.res_ready = 1'b1;
        repeat (3) send_bit(1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_mismatches !== CW'(0)) begin
            errors++; $display("FAIL midreset outputs: got valid %b ready %b mis %0d expected 0 1 0", bus.res_valid, bus.in_ready, bus.res_mismatches);
        end
        #2 rst_n = 1'b1;
        tick();
        f = '1;
        for (int i = 0; i < FL - 3; i++) send_bit(f[i]);
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL midreset stale frame: got res_valid %b expected 0", bus.res_valid); end
        for (int i = FL - 3; i < FL; i++) send_bit(f[i]);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_equal !== 1'b1 || bus.res_mismatches !== CW'(0)) begin
            errors++; $display("FAIL midreset next frame: got valid %b equal %b mis %0d expected 1 1 0", bus.res_valid, bus.res_equal, bus.res_mismatches);
        end
        tick();
    endtask

    task automatic test_random();
        logic [FL-1:0] f;
        for (int n = 0; n < 25; n++) begin
            f = FL'($urandom);
            if ($urandom_range(0, 4) == 0) f = '1;
            bus.res_ready = 1'($urandom);
            for (int i = 0; i < FL; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rand in_ready frame %0d bit %0d: got %b expected 1", n, i, bus.in_ready); end
                send_bit(f[i]);
            end
            checks++; if (bus.res_valid !== 1'b1 || bus.res_equal !== (ref_mis(f) == 0) ||
                          bus.res_mismatches !== CW'(ref_mis(f)) || bus.res_first_err !== IW'(ref_first(f))) begin
                errors++; $display("FAIL rand result frame %0d (%b): got v%b eq%b mis %0d first %0d expected v1 eq%0d mis %0d first %0d",
                                   n, f, bus.res_valid, bus.res_equal, bus.res_mismatches, bus.res_first_err,
                                   (ref_mis(f) == 0), ref_mis(f), ref_first(f));
            end
            if (bus.res_ready == 1'b0) begin
                repeat ($urandom_range(1, 3)) tick();
                checks++; if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rand hold frame %0d: got valid %b ready %b expected 1 0", n, bus.res_valid, bus.in_ready); end
                bus.res_ready = 1'b1;
            end
            tick();
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rand release frame %0d: got res_valid %b expected 0", n, bus.res_valid); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.match     = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_exact_match();
        test_partial_mismatch();
        test_gaps();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/xnor_match_checker.md
# xnor_match_checker

Frame-level comparison stage that sits directly downstream of `xnor_module`. It consumes the per-bit match flag (`xnor_module.out`, 1 = bits equal) for two serial streams. It accumulates `FRAME_LEN` accepted bits into one frame and reports whether the frame matched exactly, how many bits differed, and the index of the first differing bit. Results are presented on a valid/ready output handshake.

## Interface

Parameters:
- `FRAME_LEN`, default 8: bits per frame; must be at least 2.
- `CNT_W`, default `$clog2(FRAME_LEN+1)`: width of the mismatch count.
- `IDX_W`, default `$clog2(FRAME_LEN)`: width of the bit index.

Ports:
- `clk`  in  1  single clock; all flops are rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `match` carries a valid bit this cycle.
- `match`  in  1  per-bit match flag from `xnor_module.out`.
- `in_ready`  out  1  block accepts a bit this cycle.
- `res_valid`  out  1  frame result available.
- `res_ready`  in  1  consumer takes the result.
- `res_equal`  out  1  1 = all `FRAME_LEN` bits matched.
- `res_mismatches`  out  `CNT_W`  number of bits with `match` = 0.
- `res_first_err`  out  `IDX_W`  index (0 = first accepted bit) of the first mismatch; 0 when `res_equal` = 1.

## Operation

- The FSM has two states, `COLLECT` and `REPORT`. Reset state is `COLLECT`.
- `in_ready` is decoded from state: `in_ready` = (`state` == `COLLECT`).
- A bit is accepted on a rising edge where `in_valid && in_ready`.
- In `COLLECT`, each accepted bit:
  - increments `bit_cnt`, which runs 0..`FRAME_LEN`-1;
  - increments `mis_cnt` if `match` = 0;
  - on the first mismatch of the frame (sticky `err_seen` = 0), latches `bit_cnt` into `first_idx` and sets `err_seen`.
- `in_valid` = 0 in `COLLECT` holds all counters; gaps are allowed anywhere in a frame.
- When the bit accepted has `bit_cnt` == `FRAME_LEN`-1:
  - the FSM goes to `REPORT`;
  - result registers load `res_equal` = (final `mis_cnt` == 0), `res_mismatches` = final `mis_cnt` including this bit, and `res_first_err` = final `first_idx` including this bit, or 0 if none;
  - `res_valid` is set.
- In `REPORT`:
  - `in_ready` = 0, and `match`/`in_valid` are ignored;
  - result outputs hold stable until `res_valid && res_ready`.
- On the result handshake edge, the FSM returns to `COLLECT` and clears `bit_cnt`, `mis_cnt`, `first_idx`, `err_seen`, and `res_valid`. Result data registers may retain their values.
- Arithmetic: `mis_cnt` saturates naturally at `FRAME_LEN`, because `CNT_W` holds `FRAME_LEN` exactly. No wrap can occur within a frame.
- `rst_n` low at any time, including mid-frame or in `REPORT`, immediately forces `COLLECT` and clears all counters and all outputs. A partial frame is discarded, never reported.

## Timing

- Reset values:
  - `in_ready` = 1 (state `COLLECT`)
  - `res_valid` = 0
  - `res_equal` = 0
  - `res_mismatches` = 0
  - `res_first_err` = 0
- Latency: last bit accepted at edge k → `res_valid` = 1 and result stable from edge k, i.e. visible during cycle k+1.
- `res_ready` may be high before `res_valid`. The handshake then completes on the first edge with `res_valid` = 1, and `in_ready` returns to 1 right after that edge.
- Maximum throughput: one frame per `FRAME_LEN`+1 cycles (`FRAME_LEN` accept cycles plus one `REPORT` cycle).
- There is no combinational path from `match`/`in_valid` to any output. `in_ready` depends on state only.

## Test plan

All scenarios use `FRAME_LEN` = 8.

1. Reset: hold `rst_n` = 0 for 3 cycles → `in_ready` = 1, `res_valid` = 0, `res_equal` = 0, `res_mismatches` = 0, `res_first_err` = 0.
2. Exact match: 8 consecutive bits with `match` = 1 and `res_ready` = 1 → one cycle after the 8th accept, `res_valid` = 1, `res_equal` = 1, `res_mismatches` = 0, `res_first_err` = 0. `in_ready` = 1 on the next cycle.
3. Partial mismatch: `match` sequence 1,1,0,1,1,0,1,1 → `res_equal` = 0, `res_mismatches` = 2, `res_first_err` = 2.
4. All mismatch with gaps: 8 bits with `match` = 0, `in_valid` low for 2 cycles between bits 3 and 4 → `res_mismatches` = 8, `res_first_err` = 0, exactly one result.
5. Backpressure: after a frame, hold `res_ready` = 0 for 5 cycles with `in_valid` = 1 → `in_ready` = 0, outputs stable, and no bits consumed. Raise `res_ready` → handshake completes, and the next 8 bits form a new correct frame.
6. Reset mid-frame: accept 3 bits with `match` = 0, pulse `rst_n` low asynchronously → counters clear and no `res_valid`. The following 8 bits of `match` = 1 report `res_equal` = 1, `res_mismatches` = 0.
